// File: rtl/rbz_spi_pkg.sv
// Shared types and defaults for the rbzero SPI host.
package rbz_spi_pkg;

   localparam int DATA_W_DEF = 96;
   localparam int DIV_DEF    = 2;

   localparam logic TARGET_VEC = 1'b0;
   localparam logic TARGET_REG = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_GAP
   } state_e;

endpackage

// File: rtl/rbz_spi_tick.sv
// SCLK half-period timer: down-counter that pulses tick every DIV cycles
// while enabled and reloads whenever it is disabled.
module rbz_spi_tick #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [7:0] RELOAD = 8'(DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tick_o = en_i && (cnt_q == 8'd0);

   // Reload on disable or terminal count, otherwise count down.
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || tick_o) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rbz_spi_host.sv
// SPI mode-0 host driving the rbzero vector and register slaves.
//
// state | meaning
// IDLE  | o_ready high, waiting for a request
// SETUP | CSB low, sclk low, first bit on mosi
// HIGH  | sclk high, slave samples mosi
// LOW   | sclk low, next bit shifted onto mosi
// GAP   | both CSB high for DIV cycles before returning to IDLE
module rbz_spi_host
   import rbz_spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DIV    = DIV_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_target,
   input  logic [6:0]        i_len,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_abort,
   output logic              o_vec_csb,
   output logic              o_reg_csb,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic              o_done
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [6:0]        bits_q, bits_d;
   logic              vec_csb_q, vec_csb_d;
   logic              reg_csb_q, reg_csb_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;

   logic              tick;
   logic              accept;
   logic              abort_hit;
   logic [6:0]        len_eff;

   assign accept    = i_valid && ready_q;
   assign abort_hit = i_abort && (state_q inside {ST_SETUP, ST_HIGH, ST_LOW});
   assign len_eff   = ({25'd0, i_len} > 32'(DATA_W)) ? 7'(DATA_W) : i_len;

   // An abort drops the enable for one cycle so GAP starts with a full count.
   rbz_spi_tick #(.DIV(DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    ((state_q != ST_IDLE) && !abort_hit),
      .tick_o  (tick)
   );

   // Next-state and next-output logic; outputs are computed one cycle ahead.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bits_d    = bits_q;
      vec_csb_d = vec_csb_q;
      reg_csb_d = reg_csb_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      if (abort_hit) begin
         state_d   = ST_GAP;
         sclk_d    = 1'b0;
         vec_csb_d = 1'b1;
         reg_csb_d = 1'b1;
         done_d    = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (len_eff == 7'd0) begin
                     state_d = ST_GAP;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = ST_SETUP;
                     vec_csb_d = (i_target != TARGET_VEC);
                     reg_csb_d = (i_target != TARGET_REG);
                     sclk_d    = 1'b0;
                     // Left-align the payload so the first bit sits at the MSB.
                     shift_d   = i_data << (DATA_W - int'(len_eff));
                     mosi_d    = shift_d[DATA_W-1];
                     bits_d    = len_eff;
                  end
               end
            end
            ST_SETUP: begin
               if (tick) begin
                  state_d = ST_HIGH;
                  sclk_d  = 1'b1;
               end
            end
            ST_HIGH: begin
               if (tick) begin
                  state_d = ST_LOW;
                  sclk_d  = 1'b0;
                  shift_d = shift_q << 1;
                  mosi_d  = shift_d[DATA_W-1];
                  bits_d  = bits_q - 7'd1;
               end
            end
            ST_LOW: begin
               if (tick) begin
                  if (bits_q != 7'd0) begin
                     state_d = ST_HIGH;
                     sclk_d  = 1'b1;
                  end else begin
                     state_d   = ST_GAP;
                     vec_csb_d = 1'b1;
                     reg_csb_d = 1'b1;
                     done_d    = 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (tick) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      ready_d = (state_d == ST_IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bits_q    <= '0;
         vec_csb_q <= 1'b1;
         reg_csb_q <= 1'b1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bits_q    <= bits_d;
         vec_csb_q <= vec_csb_d;
         reg_csb_q <= reg_csb_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   assign o_ready   = ready_q;
   assign o_vec_csb = vec_csb_q;
   assign o_reg_csb = reg_csb_q;
   assign o_sclk    = sclk_q;
   assign o_mosi    = mosi_q;
   assign o_done    = done_q;

endmodule
